// File: rtl/tetris_input_pkg.sv
// Shared definitions for the Tetris input controller: command encoding,
// key indices, PS/2 scan codes, and small decode/priority helpers.
package tetris_input_pkg;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_LEFT   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_DOWN   = 3'd3,
    CMD_ROTATE = 3'd4,
    CMD_DROP   = 3'd5
  } cmd_e;

  // Key index = bit position in the held/pending maps; command code = index + 1.
  localparam logic [2:0] KEY_LEFT   = 3'd0;
  localparam logic [2:0] KEY_RIGHT  = 3'd1;
  localparam logic [2:0] KEY_DOWN   = 3'd2;
  localparam logic [2:0] KEY_ROTATE = 3'd3;
  localparam logic [2:0] KEY_DROP   = 3'd4;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_EXT,
    PS_BRK,
    PS_EXT_BRK
  } parse_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_sel_t;

  // Arrow keys only count with the E0 prefix; space only without it.
  function automatic key_sel_t decode_key(input logic ext, input logic [7:0] code);
    key_sel_t r;
    r = '{hit: 1'b0, idx: KEY_LEFT};
    if (ext) begin
      case (code)
        SC_LEFT:  r = '{hit: 1'b1, idx: KEY_LEFT};
        SC_RIGHT: r = '{hit: 1'b1, idx: KEY_RIGHT};
        SC_DOWN:  r = '{hit: 1'b1, idx: KEY_DOWN};
        SC_UP:    r = '{hit: 1'b1, idx: KEY_ROTATE};
        default:  r = '{hit: 1'b0, idx: KEY_LEFT};
      endcase
    end else if (code == SC_SPACE) begin
      r = '{hit: 1'b1, idx: KEY_DROP};
    end
    return r;
  endfunction

  function automatic logic [4:0] key_bit(input logic [2:0] idx);
    return 5'b00001 << idx;
  endfunction

  // Fixed priority DROP > ROTATE > LEFT > RIGHT > DOWN.
  function automatic key_sel_t pick_pending(input logic [4:0] pend);
    key_sel_t r;
    r = '{hit: 1'b0, idx: KEY_LEFT};
    if      (pend[KEY_DROP])   r = '{hit: 1'b1, idx: KEY_DROP};
    else if (pend[KEY_ROTATE]) r = '{hit: 1'b1, idx: KEY_ROTATE};
    else if (pend[KEY_LEFT])   r = '{hit: 1'b1, idx: KEY_LEFT};
    else if (pend[KEY_RIGHT])  r = '{hit: 1'b1, idx: KEY_RIGHT};
    else if (pend[KEY_DOWN])   r = '{hit: 1'b1, idx: KEY_DOWN};
    return r;
  endfunction

endpackage

// File: rtl/tetris_input_ctrl_if.sv
// Byte-in / command-out bundle between PS/2 receiver, controller and game core.
interface tetris_input_ctrl_if;
  logic [7:0] code;
  logic       code_valid;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [4:0] keys_held;

  modport master (output code, code_valid, cmd_ready, input cmd_valid, cmd, keys_held);
  modport slave  (input code, code_valid, cmd_ready, output cmd_valid, cmd, keys_held);
endinterface

// File: rtl/ps2_code_parser.sv
// Tracks E0/F0 prefixes across scan-code bytes and emits one-cycle make/break
// pulses for recognised game keys.
module ps2_code_parser
  import tetris_input_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [7:0] code,
  output logic [2:0] key_idx,
  output logic       make_p,
  output logic       brk_p
);

  parse_state_e state_q, state_d;
  key_sel_t     dec;

  // Prefix state register.
  // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= PS_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and decode; pulses only fire on the byte that completes a sequence.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    make_p  = 1'b0;
    brk_p   = 1'b0;
    dec     = decode_key(state_q == PS_EXT || state_q == PS_EXT_BRK, code);
    key_idx = dec.idx;
    if (code_valid) begin
      case (state_q)
        PS_IDLE: begin
          if      (code == SC_EXT) state_d = PS_EXT;
          else if (code == SC_BRK) state_d = PS_BRK;
          else                     make_p  = dec.hit;
        end
        PS_EXT: begin
          if      (code == SC_BRK) state_d = PS_EXT_BRK;
          else if (code == SC_EXT) state_d = PS_EXT;
          else begin
            make_p  = dec.hit;
            state_d = PS_IDLE;
          end
        end
        PS_BRK: begin
          if (code != SC_BRK) begin
            brk_p   = dec.hit;
            state_d = PS_IDLE;
          end
        end
        PS_EXT_BRK: begin
          if (code != SC_BRK && code != SC_EXT) begin
            brk_p   = dec.hit;
            state_d = PS_IDLE;
          end
        end
        default: state_d = PS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Turns key make/break events into game commands: held map, one-shot pending
// flags, DAS/ARR auto-repeat for the latest movement key, priority arbiter
// and a registered valid/ready output slot.
module tetris_input_ctrl
  import tetris_input_pkg::*;
#(
  parameter int DAS_CYC = 17_000_000,
  parameter int ARR_CYC = 5_000_000,
  parameter int TW      = 25
) (
  input logic                clk,
  input logic                rst_n,
  tetris_input_ctrl_if.slave bus
);

  localparam logic [TW-1:0] DAS_LOAD = TW'(DAS_CYC - 1);
  localparam logic [TW-1:0] ARR_LOAD = TW'(ARR_CYC - 1);

  logic [2:0]    key_idx;
  logic          make_p, brk_p;

  logic [4:0]    held_q, held_d, pend_q, pend_d;
  logic          rep_vld_q, rep_vld_d;
  logic [2:0]    rep_key_q, rep_key_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [2:0]    cmd_q, cmd_d;
  logic          make_new, rep_fire, slot_free;
  key_sel_t      grant;

  ps2_code_parser u_parser (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (bus.code_valid),
    .code       (bus.code),
    .key_idx    (key_idx),
    .make_p     (make_p),
    .brk_p      (brk_p)
  );

  // Next-state for key maps, repeat timer and output slot. Later assignments
  // win: pending sets override the arbiter's clear, a make's reload overrides expiry.
  always_comb begin
    make_new    = make_p && !held_q[key_idx];
    rep_fire    = rep_vld_q && (timer_q == '0);
    slot_free   = !cmd_valid_q || bus.cmd_ready;
    grant       = pick_pending(pend_q);
    held_d      = held_q;
    pend_d      = pend_q;
    rep_vld_d   = rep_vld_q;
    rep_key_d   = rep_key_q;
    timer_d     = timer_q;
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;

    if (slot_free) begin
      cmd_valid_d = grant.hit;
      cmd_d       = grant.hit ? (grant.idx + 3'd1) : CMD_NONE;
      if (grant.hit) pend_d = pend_d & ~key_bit(grant.idx);
    end

    if (rep_vld_q) timer_d = rep_fire ? ARR_LOAD : (timer_q - TW'(1));
    if (rep_fire)  pend_d  = pend_d | key_bit(rep_key_q);

    if (make_new) begin
      held_d = held_d | key_bit(key_idx);
      pend_d = pend_d | key_bit(key_idx);
      if (key_idx <= KEY_DOWN) begin
        rep_vld_d = 1'b1;
        rep_key_d = key_idx;
        timer_d   = DAS_LOAD;
      end
    end

    if (brk_p) begin
      held_d = held_d & ~key_bit(key_idx);
      if (rep_vld_q && key_idx == rep_key_q) begin
        rep_vld_d = 1'b0;
        timer_d   = '0;
      end
    end
  end

  // State registers.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_q      <= '0;
      pend_q      <= '0;
      rep_vld_q   <= 1'b0;
      rep_key_q   <= KEY_LEFT;
      timer_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NONE;
    end else begin
      held_q      <= held_d;
      pend_q      <= pend_d;
      rep_vld_q   <= rep_vld_d;
      rep_key_q   <= rep_key_d;
      timer_q     <= timer_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd       = cmd_q;
  assign bus.keys_held = held_q;

endmodule
